// File: rtl/axis_fifo_bist_checker.sv
// -----------------------------------------------------------------------------
// axis_fifo_bist_checker
//
// Receive-side BIST engine for the inline DRAM FIFO production test. It
// consumes the 64-bit CHDR/CVITA packet stream that leaves the FIFO's BIST
// demux and checks every header and payload word against the pattern the BIST
// generator produces from the same configuration. Run status and throughput
// counters are exported for the FIFO readback mux.
//
// Ports:
//   clk        checker clock (bus_clk domain)
//   reset      synchronous, active-high reset
//   go         level; rising edge starts a run, low requests stop (cont mode)
//   cont       continuous mode, sampled at start
//   ramp       payload pattern select (0 = fixed word, 1 = 64-bit ramp)
//   num_pkts   packets per run (0 behaves as 1), sampled at start
//   pkt_len    payload bytes per packet (0 behaves as 8), sampled at start
//   seed       pattern seed, sampled at start
//   i_tdata/i_tlast/i_tvalid/i_tready   AXI-Stream input
//   running    run in progress
//   done       run finished, status held until the next start
//   error      [0] data/header mismatch seen, [1] framing error seen
//   err_cnt    mismatched words (saturating)
//   xfer_cnt   accepted beats during the run (saturating)
//   cyc_cnt    clock cycles spent running (saturating)
// -----------------------------------------------------------------------------
module axis_fifo_bist_checker #(
  parameter int          DWIDTH = 64,
  parameter logic [31:0] SID    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              cont,
  input  logic              ramp,
  input  logic [17:0]       num_pkts,
  input  logic [12:0]       pkt_len,
  input  logic [31:0]       seed,
  input  logic [DWIDTH-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic              running,
  output logic              done,
  output logic [1:0]        error,
  output logic [31:0]       err_cnt,
  output logic [31:0]       xfer_cnt,
  output logic [31:0]       cyc_cnt
);

  // DRAIN discards the tail of an over-long packet until its tlast.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DRAIN,
    S_END_CHK,
    S_DONE
  } state_t;

  state_t      state;
  logic        go_q;
  logic        cont_r;
  logic        ramp_r;
  logic [17:0] num_pkts_r;
  logic [17:0] pkt_cnt;
  logic [15:0] len_r;
  logic [10:0] nwords_r;
  logic [10:0] word_idx;
  logic [31:0] seed_r;
  logic [63:0] ramp_val;
  logic [11:0] seq;

  logic [12:0] pkt_len_eff;
  logic [17:0] num_pkts_eff;
  logic [10:0] nwords_start;
  logic        start;
  logic        beat;
  logic        last_idx;
  logic        hdr_bad;
  logic        data_bad;
  logic [63:0] exp_hdr;
  logic [63:0] exp_data;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // NOTE: every signal is assigned unconditionally here, so no latch can be
  // inferred even as branches are added later.
  always_comb begin
    pkt_len_eff  = (pkt_len == 13'd0) ? 13'd8 : pkt_len;
    num_pkts_eff = (num_pkts == 18'd0) ? 18'd1 : num_pkts;
    nwords_start = 11'(({1'b0, pkt_len_eff} + 14'd7) >> 3);
    start        = go & ~go_q & ((state == S_IDLE) || (state == S_DONE));
    beat         = i_tvalid & i_tready;
    exp_hdr      = {4'b0000, seq, len_r, SID};
    exp_data     = ramp_r ? ramp_val : {seed_r, ~seed_r};
    hdr_bad      = (i_tdata != exp_hdr);
    data_bad     = (i_tdata != exp_data);
    last_idx     = (word_idx == nwords_r - 11'd1);
  end

  // NOTE: state uses non-blocking assignments only; every branch below reads
  // the pre-edge values, so statement order inside the block does not matter
  // except that a later assignment to the same register wins.
  always_ff @(posedge clk) begin
    // NOTE: configuration and pattern registers are reset along with the
    // control state so a reset mid-run leaves no stale run context behind.
    if (reset) begin
      state      <= S_IDLE;
      go_q       <= 1'b0;
      cont_r     <= 1'b0;
      ramp_r     <= 1'b0;
      num_pkts_r <= '0;
      pkt_cnt    <= '0;
      len_r      <= '0;
      nwords_r   <= '0;
      word_idx   <= '0;
      seed_r     <= '0;
      ramp_val   <= '0;
      seq        <= '0;
      i_tready   <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      error      <= 2'b00;
      err_cnt    <= '0;
      xfer_cnt   <= '0;
      cyc_cnt    <= '0;
    end else begin
      go_q <= go;

      if (running) cyc_cnt <= sat_inc(cyc_cnt);
      if (beat)    xfer_cnt <= sat_inc(xfer_cnt);

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cont_r     <= cont;
            ramp_r     <= ramp;
            num_pkts_r <= num_pkts_eff;
            len_r      <= 16'(pkt_len_eff) + 16'd8;
            nwords_r   <= nwords_start;
            seed_r     <= seed;
            ramp_val   <= {32'h0, seed};
            seq        <= '0;
            pkt_cnt    <= '0;
            error      <= 2'b00;
            err_cnt    <= '0;
            xfer_cnt   <= '0;
            cyc_cnt    <= '0;
            done       <= 1'b0;
            running    <= 1'b1;
            i_tready   <= 1'b1;
            state      <= S_HDR;
          end
        end

        S_HDR: begin
          if (beat) begin
            if (hdr_bad) begin
              error[0] <= 1'b1;
              err_cnt  <= sat_inc(err_cnt);
            end
            if (i_tlast) begin
              // Header-only packet: framing error, no payload to check.
              error[1] <= 1'b1;
              pkt_cnt  <= pkt_cnt + 18'd1;
              i_tready <= 1'b0;
              state    <= S_END_CHK;
            end else begin
              word_idx <= '0;
              state    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (beat) begin
            if (data_bad) begin
              error[0] <= 1'b1;
              err_cnt  <= sat_inc(err_cnt);
            end
            // The ramp advances per checked word and carries across packets.
            ramp_val <= ramp_val + 64'd1;
            if (i_tlast) begin
              if (!last_idx) error[1] <= 1'b1;
              pkt_cnt  <= pkt_cnt + 18'd1;
              seq      <= seq + 12'd1;
              i_tready <= 1'b0;
              state    <= S_END_CHK;
            end else if (last_idx) begin
              error[1] <= 1'b1;
              state    <= S_DRAIN;
            end else begin
              word_idx <= word_idx + 11'd1;
            end
          end
        end

        S_DRAIN: begin
          if (beat && i_tlast) begin
            pkt_cnt  <= pkt_cnt + 18'd1;
            seq      <= seq + 12'd1;
            i_tready <= 1'b0;
            state    <= S_END_CHK;
          end
        end

        S_END_CHK: begin
          if ((!cont_r && (pkt_cnt == num_pkts_r)) ||
              (cont_r && (!go || (error != 2'b00)))) begin
            running <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            i_tready <= 1'b1;
            state    <= S_HDR;
          end
        end

        default: begin
          i_tready <= 1'b0;
          running  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
